// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Shared timing constants and decoder state type for the
//                VGA sync decoder. The default totals describe 640x480@60Hz
//                on a 25 MHz pixel clock.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  localparam int H_TOTAL_DEFAULT     = 800;
  localparam int V_TOTAL_DEFAULT     = 525;
  localparam int H_ACTIVE_DEFAULT    = 640;
  localparam int V_ACTIVE_DEFAULT    = 480;
  localparam int LOCK_FRAMES_DEFAULT = 2;

  // Line-length counter is 11 bits wide so a stalled h_sync can be seen
  // well beyond twice a nominal line before it saturates.
  localparam int HCNT_W = 11;
  localparam logic [HCNT_W-1:0] HCNT_MAX = '1;
  localparam logic [9:0]        LCNT_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } sync_state_e;

endpackage
`default_nettype wire

// File: rtl/vga_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : vga_edge_det
//  Description : Registers one synchronous input and flags its falling edge
//                (previous sample 1, current sample 0).
//  Ports       : clk      - pixel clock
//                rst_n    - synchronous active-low reset
//                din      - input level from the timing source
//                level    - registered input level
//                fall     - high for the cycle after a 1->0 transition
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_edge_det #(
  parameter logic RESET_VAL = 1'b1   // idle level loaded on reset
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic fall
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level  <= RESET_VAL;
      r_prev <= RESET_VAL;
    end else begin
      level  <= din;
      r_prev <= level;
    end
  end

  assign fall = r_prev & ~level;

endmodule
`default_nettype wire

// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_decoder
//  Description : Sink side of a VGA timing interface. Recovers pixel
//                coordinates from h_sync/v_sync/onscreen, measures line
//                length and frame height, and reports lock and errors.
//  Ports       : clk, rst_n           - pixel clock, sync active-low reset
//                h_sync, v_sync       - active-low syncs from timing source
//                onscreen             - active-video flag
//                x, y                 - pixel column / active line index
//                pixel_valid          - x/y valid (locked and onscreen)
//                frame_start          - pulse on each v_sync falling edge
//                locked               - timing verified for LOCK_FRAMES frames
//                err                  - pulse on measurement mismatch/timeout
//                line_len             - last measured line length (clocks)
//                frame_lines          - last measured frame height (lines)
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_DEFAULT,
  parameter int V_TOTAL     = V_TOTAL_DEFAULT,
  parameter int H_ACTIVE    = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE    = V_ACTIVE_DEFAULT,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic       onscreen,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       err,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines
);

  localparam logic [HCNT_W-1:0] C_H_TOTAL  = HCNT_W'(H_TOTAL);
  localparam logic [HCNT_W-1:0] C_TIMEOUT  = HCNT_W'(2 * H_TOTAL);
  localparam logic [9:0]        C_V_TOTAL  = 10'(V_TOTAL);
  localparam logic [9:0]        C_H_ACTIVE = 10'(H_ACTIVE);
  localparam logic [9:0]        C_X_MAX    = 10'(H_ACTIVE - 1);
  localparam logic [9:0]        C_Y_MAX    = 10'(V_ACTIVE - 1);
  localparam logic [3:0]        C_LOCK     = 4'(LOCK_FRAMES);

  // --------------------------------------------------------------------------
  // Input registers and edge detection
  // --------------------------------------------------------------------------
  logic w_h_lvl, w_h_fall;
  logic w_v_lvl, w_v_fall;
  logic w_on_lvl, w_on_fall;

  vga_edge_det #(.RESET_VAL(1'b1)) u_h_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (h_sync),
    .level (w_h_lvl),
    .fall  (w_h_fall)
  );

  vga_edge_det #(.RESET_VAL(1'b1)) u_v_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (v_sync),
    .level (w_v_lvl),
    .fall  (w_v_fall)
  );

  // onscreen idles low, so it resets low to avoid a false falling edge.
  vga_edge_det #(.RESET_VAL(1'b0)) u_on_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (onscreen),
    .level (w_on_lvl),
    .fall  (w_on_fall)
  );

  // Only the sync edges matter downstream; their levels are not consumed.
  logic w_unused_lvl;
  assign w_unused_lvl = w_h_lvl ^ w_v_lvl;

  // --------------------------------------------------------------------------
  // Counters and measurement checks
  // --------------------------------------------------------------------------
  sync_state_e       r_state;
  logic [HCNT_W-1:0] r_h_cnt;
  logic [9:0]        r_l_cnt;
  logic [9:0]        r_x_cnt;
  logic [9:0]        r_y_cnt;
  logic [3:0]        r_good_cnt;
  logic              r_h_seen;   // a checked line start has been observed

  logic [9:0] w_l_cnt_eff;
  logic [3:0] w_good_inc;
  logic       w_active, w_h_bad, w_v_bad, w_x_overrun, w_timeout;
  logic       w_mismatch, w_lock_nxt, w_valid_nxt;

  // A line start coinciding with the frame start is counted into the
  // frame that is ending.
  always_comb begin
    w_l_cnt_eff = r_l_cnt;
    if (w_h_fall && (r_l_cnt != LCNT_MAX)) begin
      w_l_cnt_eff = r_l_cnt + 10'd1;
    end
  end

  assign w_good_inc  = r_good_cnt + 4'd1;
  assign w_active    = (r_state != SEARCH);
  assign w_h_bad     = w_h_fall & r_h_seen & (r_h_cnt != C_H_TOTAL);
  assign w_v_bad     = w_v_fall & (w_l_cnt_eff != C_V_TOTAL);
  // r_x_cnt parks at H_ACTIVE once a line has produced every pixel, so any
  // further onscreen cycle is one pixel too many.
  assign w_x_overrun = w_on_lvl & (r_x_cnt == C_H_ACTIVE);
  assign w_timeout   = (r_h_cnt >= C_TIMEOUT);
  assign w_mismatch  = w_active & (w_h_bad | w_v_bad | w_x_overrun | w_timeout);

  assign w_lock_nxt  = ~w_mismatch &
                       ((r_state == LOCKED) ||
                        ((r_state == MEASURE) && w_v_fall && (w_good_inc == C_LOCK)));
  assign w_valid_nxt = w_lock_nxt & w_on_lvl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h_cnt  <= '0;
      r_l_cnt  <= '0;
      r_x_cnt  <= '0;
      r_y_cnt  <= '0;
      r_h_seen <= 1'b0;
    end else begin
      if (w_h_fall) begin
        r_h_cnt <= HCNT_W'(1);
      end else if (r_h_cnt != HCNT_MAX) begin
        r_h_cnt <= r_h_cnt + HCNT_W'(1);
      end

      if (w_v_fall) begin
        r_l_cnt <= '0;
      end else if (w_h_fall) begin
        r_l_cnt <= w_l_cnt_eff;
      end

      if (!w_on_lvl) begin
        r_x_cnt <= '0;
      end else if (r_x_cnt != C_H_ACTIVE) begin
        r_x_cnt <= r_x_cnt + 10'd1;
      end

      if (w_v_fall) begin
        r_y_cnt <= '0;
      end else if (w_on_fall && (r_y_cnt != C_Y_MAX)) begin
        r_y_cnt <= r_y_cnt + 10'd1;
      end

      // The first line start after leaving SEARCH only arms the check,
      // since the preceding interval was not measured under lock.
      if ((r_state == SEARCH) || w_mismatch) begin
        r_h_seen <= 1'b0;
      end else if (w_h_fall) begin
        r_h_seen <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Lock state machine with registered status outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= SEARCH;
      r_good_cnt  <= '0;
      locked      <= 1'b0;
      err         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      err         <= w_mismatch;
      frame_start <= w_v_fall;
      locked      <= w_lock_nxt;
      case (r_state)
        SEARCH: begin
          if (w_v_fall) begin
            r_state    <= MEASURE;
            r_good_cnt <= '0;
          end
        end
        MEASURE: begin
          if (w_mismatch) begin
            r_state    <= SEARCH;
            r_good_cnt <= '0;
          end else if (w_v_fall) begin
            r_good_cnt <= w_good_inc;
            if (w_good_inc == C_LOCK) begin
              r_state <= LOCKED;
            end
          end
        end
        default: begin
          if (w_mismatch) begin
            r_state    <= SEARCH;
            r_good_cnt <= '0;
          end
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Coordinate and measurement outputs (held while not updated)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      pixel_valid <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
    end else begin
      pixel_valid <= w_valid_nxt;
      if (w_valid_nxt) begin
        x <= (r_x_cnt > C_X_MAX) ? C_X_MAX : r_x_cnt;
        y <= r_y_cnt;
      end
      if (w_h_fall) begin
        line_len <= r_h_cnt[9:0];
      end
      if (w_v_fall) begin
        frame_lines <= w_l_cnt_eff;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sync_decoder
//  Description : Randomized scoreboard bench for vga_sync_decoder using a
//                scaled-down raster so many frames fit in a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_decoder;

  localparam int HT = 32, VT = 10, HA = 20, VA = 6, LF = 2;
  localparam int HS_START = 24, HS_W = 4, VS_START = 7, VS_W = 2;
  localparam int FR = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, h_sync = 1'b1, v_sync = 1'b1, onscreen = 1'b0;
  logic [9:0] x, y, line_len, frame_lines;
  logic       pixel_valid, frame_start, locked, err;

  vga_sync_decoder #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .h_sync(h_sync), .v_sync(v_sync), .onscreen(onscreen),
    .x(x), .y(y), .pixel_valid(pixel_valid), .frame_start(frame_start),
    .locked(locked), .err(err), .line_len(line_len), .frame_lines(frame_lines)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       pv;
    logic       fs;
    logic       lk;
    logic       er;
    logic [9:0] ll;
    logic [9:0] fl;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // ---------------- reference model (event timestamps) ----------------
  int   m_e = 0, m_last_h = 0, m_lines = 0, m_on_start = 0, m_yact = 0;
  int   m_mode = 0, m_good = 0;     // mode: 0 search, 1 measure, 2 locked
  bit   m_hchk = 0;
  bit   m_cur_h = 1, m_cur_v = 1, m_cur_on = 0;
  bit   m_prev_h = 1, m_prev_v = 1, m_prev_on = 0;
  exp_t m_out = '0;

  task automatic model_step(input bit r, input bit h, input bit v, input bit on);
    bit hf, vf, of, bad, lk, pv;
    int len, lines_v, idx, old_mode;
    m_e++;
    if (!r) begin
      m_mode = 0; m_good = 0; m_hchk = 0; m_lines = 0; m_yact = 0;
      m_last_h = m_e + 1;           // length reads 0 on the first cycle after reset
      m_out = '0;
      m_cur_h = 1; m_cur_v = 1; m_cur_on = 0;
      m_prev_h = 1; m_prev_v = 1; m_prev_on = 0;
      return;
    end
    hf = m_prev_h && !m_cur_h;
    vf = m_prev_v && !m_cur_v;
    of = m_prev_on && !m_cur_on;
    len = m_e - m_last_h;
    if (len > 2047) len = 2047;
    lines_v = m_lines + (hf ? 1 : 0);
    if (lines_v > 1023) lines_v = 1023;
    if (m_cur_on && !m_prev_on) m_on_start = m_e;
    idx = m_cur_on ? (m_e - m_on_start) : 0;
    bad = (m_mode != 0) &&
          ((hf && m_hchk && len != HT) || (vf && lines_v != VT) ||
           (m_cur_on && idx >= HA) || (len >= 2 * HT));
    old_mode = m_mode;
    if (m_mode == 0) begin
      if (vf) begin m_mode = 1; m_good = 0; end
    end else if (bad) begin
      m_mode = 0; m_good = 0;
    end else if (vf && m_mode == 1) begin
      m_good++;
      if (m_good == LF) m_mode = 2;
    end
    if (old_mode == 0 || bad) m_hchk = 0;
    else if (hf) m_hchk = 1;
    lk = (m_mode == 2);
    pv = lk && m_cur_on;
    m_out.fs = vf;
    m_out.er = bad;
    m_out.lk = lk;
    m_out.pv = pv;
    if (hf) m_out.ll = 10'(len % 1024);
    if (vf) m_out.fl = 10'(lines_v);
    if (pv) begin
      m_out.x = 10'((idx > HA - 1) ? HA - 1 : idx);
      m_out.y = 10'((m_yact > VA - 1) ? VA - 1 : m_yact);
    end
    if (hf) m_last_h = m_e;
    if (vf) m_lines = 0;
    else if (hf) m_lines++;
    if (vf) m_yact = 0;
    else if (of) m_yact++;
    m_prev_h = m_cur_h; m_prev_v = m_cur_v; m_prev_on = m_cur_on;
    m_cur_h = h; m_cur_v = v; m_cur_on = on;
  endtask

  // Apply one cycle of pins and queue the response expected after the edge.
  task automatic cyc(input bit r, input bit h, input bit v, input bit on);
    rst_n = r; h_sync = h; v_sync = v; onscreen = on;
    model_step(r, h, v, on);
    exp_q.push_back(m_out);
    @(posedge clk);
    #1;
  endtask

  // ---------------- raster source ----------------
  int g_hpos = 0, g_vpos = 0, g_line_tot = HT, g_frame_tot = VT, g_hold = 0;
  bit g_vs_hfall = 0, g_on_ext = 0;

  task automatic gen_cycle(input bit r);
    bit h, v, on;
    h = !(g_hpos >= HS_START && g_hpos < HS_START + HS_W);
    if (g_hold > 0) begin h = 1; g_hold--; end
    if (!g_vs_hfall)
      v = !(g_vpos >= VS_START && g_vpos < VS_START + VS_W);
    else
      v = !((g_vpos == VS_START && g_hpos >= HS_START) ||
            (g_vpos > VS_START && g_vpos < VS_START + VS_W) ||
            (g_vpos == VS_START + VS_W && g_hpos < HS_START));
    on = (g_hpos < (g_on_ext ? HA + 3 : HA)) && (g_vpos < VA);
    cyc(r, h, v, on);
    g_hpos++;
    if (g_hpos >= g_line_tot) begin
      g_hpos = 0; g_line_tot = HT; g_on_ext = 0;
      g_vpos++;
      if (g_vpos >= g_frame_tot) begin g_vpos = 0; g_frame_tot = VT; end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) gen_cycle(1'b1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t a, e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a.x = x; a.y = y; a.pv = pixel_valid; a.fs = frame_start;
        a.lk = locked; a.er = err; a.ll = line_len; a.fl = frame_lines;
        n_vec++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs @%0t: got x=%0d y=%0d pv=%0b fs=%0b lk=%0b err=%0b ll=%0d fl=%0d, need x=%0d y=%0d pv=%0b fs=%0b lk=%0b err=%0b ll=%0d fl=%0d",
                   $time, a.x, a.y, a.pv, a.fs, a.lk, a.er, a.ll, a.fl,
                   e.x, e.y, e.pv, e.fs, e.lk, e.er, e.ll, e.fl);
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    g_hpos = $urandom_range(0, HT - 1);
    g_vpos = $urandom_range(0, VT - 1);
    repeat (3) gen_cycle(1'b0);
    run(5 * FR);
    for (int ep = 0; ep < 30; ep++) begin
      case ($urandom_range(0, 7))
        0: run(FR * $urandom_range(1, 3));
        1: begin
          g_line_tot = ($urandom_range(0, 1) != 0) ? HT + 1 : HT - 1;
          run(3 * FR + HT);
        end
        2: begin
          g_hold = $urandom_range(2 * HT - 8, 2 * HT + 40);
          run(g_hold + 3 * FR);
        end
        3: begin
          g_frame_tot = VT - 1;
          run(4 * FR);
        end
        4: begin
          g_vs_hfall = ~g_vs_hfall;
          run(3 * FR + HT);
        end
        5: begin
          g_on_ext = 1;
          run(3 * FR + HT);
        end
        6: begin
          run($urandom_range(0, FR));
          repeat (3) gen_cycle(1'b0);
          run(4 * FR);
        end
        default: begin
          repeat ($urandom_range(20, 200))
            cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
          run(3 * FR);
        end
      endcase
    end
    // Long stall: drives the line counter into saturation.
    g_hold = 2200;
    run(2200 + 3 * FR);
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected responses left, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
